// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: writeback source select and load funct3 codes.
package pipe_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_LFW = 3'b111;

endpackage

// File: rtl/load_extract.sv
// Combinational load-lane select and sign/zero extension; shared with the load-forwarding path.
module load_extract
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  ext
);

  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic [OFF_W-1:0] w_half_off;
  logic [OFF_W-1:0] w_word_off;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;

  // Lanes are picked by shifting the word down by the aligned byte offset.
  assign w_half_off = off & HALF_MASK;
  assign w_word_off = off & WORD_MASK;
  assign w_byte     = 8'(rdata >> {off, 3'b000});
  assign w_half     = 16'(rdata >> {w_half_off, 3'b000});
  assign w_word     = 32'(rdata >> {w_word_off, 3'b000});

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_LB:  ext = XLEN'($signed(w_byte));
      F3_LH:  ext = XLEN'($signed(w_half));
      F3_LW:  ext = XLEN'($signed(w_word));
      F3_LBU: ext = XLEN'(w_byte);
      F3_LHU: ext = XLEN'(w_half);
      F3_LWU: ext = (XLEN == 64) ? XLEN'(w_word) : XLEN'($signed(w_word));
      F3_LD:  ext = (XLEN == 64) ? rdata : XLEN'($signed(w_word));
      F3_LFW: ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage: result select plus a main/skid register pair so writeback can stall
// without losing records; in_ready comes straight from the skid valid flop.
module mem_wb_skid_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_wbsel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_link_pc,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RA_W-1:0] out_rd,
  output logic            out_regwrite,
  output logic [XLEN-1:0] out_result
);

  // Record layout depends on the module parameters, so it is declared here.
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic [XLEN-1:0] result;
  } wb_rec_t;

  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;
  wb_rec_t         w_in_rec;
  logic            w_in_fire;
  logic            w_out_fire;

  wb_rec_t r_main;
  wb_rec_t r_skid;
  logic    r_main_vld;
  logic    r_skid_vld;

  load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_extract (
    .rdata  (in_mem_rdata),
    .off    (in_alu_result[OFF_W-1:0]),
    .funct3 (in_funct3),
    .ext    (w_load)
  );

  always_comb begin
    w_result = in_alu_result;
    case (in_wbsel)
      WB_ALU:  w_result = in_alu_result;
      WB_MEM:  w_result = w_load;
      WB_PC:   w_result = in_link_pc;
      WB_CSR:  w_result = in_csr_rdata;
      default: w_result = in_alu_result;
    endcase
  end

  // Writes to x0 are squashed once here so downstream never sees them.
  assign w_in_rec.rd       = in_rd;
  assign w_in_rec.regwrite = in_regwrite && (in_rd != '0);
  assign w_in_rec.result   = w_result;

  assign in_ready   = !r_skid_vld;
  assign w_in_fire  = in_valid && !r_skid_vld;
  assign w_out_fire = r_main_vld && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_main_vld || w_out_fire) begin
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_main_vld <= w_in_fire;
        if (w_in_fire) begin
          r_main <= w_in_rec;
        end
      end
    end else if (w_in_fire) begin
      r_skid     <= w_in_rec;
      r_skid_vld <= 1'b1;
    end
  end

  assign out_valid    = r_main_vld;
  assign out_rd       = r_main.rd;
  assign out_regwrite = r_main_vld && r_main.regwrite;
  assign out_result   = r_main.result;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Scoreboard bench for mem_wb_skid_stage (XLEN=32) plus a 64-bit instance for wide loads.
module tb_mem_wb_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic [1:0]  in_wbsel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_link_pc = 32'h104;
  logic [31:0] in_csr_rdata = 32'hC5C5_0001;
  logic [31:0] in_mem_rdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic [31:0] out_result;

  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [63:0] d_alu = '0;
  logic [63:0] d_mem = '0;
  logic [2:0]  d_f3 = '0;
  logic        d_out_valid;
  logic [4:0]  d_out_rd;
  logic        d_out_rw;
  logic [63:0] d_out_result;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  mem_wb_skid_stage #(.XLEN(32), .RA_W(5)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_wbsel(in_wbsel), .in_alu_result(in_alu_result), .in_link_pc(in_link_pc),
    .in_csr_rdata(in_csr_rdata), .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_result(out_result)
  );

  mem_wb_skid_stage #(.XLEN(64), .RA_W(5)) u_dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(d_valid), .in_ready(d_ready), .in_rd(5'd3), .in_regwrite(1'b1),
    .in_wbsel(2'd1), .in_alu_result(d_alu), .in_link_pc(64'h0),
    .in_csr_rdata(64'h0), .in_mem_rdata(d_mem), .in_funct3(d_f3),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_rd(d_out_rd),
    .out_regwrite(d_out_rw), .out_result(d_out_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one record for one cycle; pushes the expectation if the stage takes it.
  task automatic drive_rec(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] mem,
                           input logic [2:0] f3, input logic [31:0] exp, output bit acc);
    exp_t e;
    in_valid = 1'b1; in_rd = rd; in_regwrite = rw; in_wbsel = sel;
    in_alu_result = alu; in_mem_rdata = mem; in_funct3 = f3;
    @(negedge clk);
    acc = in_ready && !flush;
    if (acc) begin
      e.rd = rd; e.rw = rw && (rd != 5'd0); e.res = exp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every accepted output must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_out", {32'h0, out_result}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check_eq("sb_result", {32'h0, out_result}, {32'h0, e.res});
          check_eq("sb_rd", {59'h0, out_rd}, {59'h0, e.rd});
          check_eq("sb_regwrite", {63'h0, out_regwrite}, {63'h0, e.rw});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] ld_off [5] = '{32'd3, 32'd1, 32'd2, 32'd0, 32'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

  initial begin
    bit acc;
    logic [31:0] stream_v [3] = '{32'h11, 32'h22, 32'h33};

    #12;
    check_eq("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check_eq("rst_out_regwrite", {63'h0, out_regwrite}, 64'd0);
    check_eq("rst_out_rd", {59'h0, out_rd}, 64'd0);
    check_eq("rst_out_result", {32'h0, out_result}, 64'd0);
    check_eq("rst_in_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream, one cycle latency, continuous valid
    for (int i = 0; i < 3; i++) begin
      drive_rec(5'd1 + 5'(i), 1'b1, 2'd0, stream_v[i], 32'h0, 3'b000, stream_v[i], acc);
      check_eq("stream_accept", {63'h0, acc}, 64'd1);
      check_eq("stream_valid", {63'h0, out_valid}, 64'd1);
      check_eq("stream_result", {32'h0, out_result}, {32'h0, stream_v[i]});
    end

    for (int i = 0; i < 5; i++) begin
      drive_rec(5'd7, 1'b1, 2'd1, 32'h1000 | ld_off[i], 32'h80FF7F01, ld_f3[i][2:0], ld_exp[i], acc);
      check_eq("load_result", {32'h0, out_result}, {32'h0, ld_exp[i]});
    end

    drive_rec(5'd0, 1'b1, 2'd0, 32'h55, 32'h0, 3'b000, 32'h55, acc);
    check_eq("x0_valid", {63'h0, out_valid}, 64'd1);
    check_eq("x0_regwrite", {63'h0, out_regwrite}, 64'd0);

    drive_rec(5'd1, 1'b1, 2'd2, 32'h0, 32'h0, 3'b000, 32'h104, acc);
    check_eq("link_pc", {32'h0, out_result}, 64'h104);
    drive_rec(5'd2, 1'b1, 2'd3, 32'h0, 32'h0, 3'b000, 32'hC5C50001, acc);
    check_eq("csr", {32'h0, out_result}, 64'hC5C50001);
    in_valid = 1'b0;
    drain();

    // Backpressure: A held, B in skid, C refused until the stall clears
    out_ready = 1'b0;
    drive_rec(5'd10, 1'b1, 2'd0, 32'hA, 32'h0, 3'b000, 32'hA, acc);
    check_eq("bp_accept_a", {63'h0, acc}, 64'd1);
    drive_rec(5'd11, 1'b1, 2'd0, 32'hB, 32'h0, 3'b000, 32'hB, acc);
    check_eq("bp_accept_b", {63'h0, acc}, 64'd1);
    check_eq("bp_in_ready_low", {63'h0, in_ready}, 64'd0);
    drive_rec(5'd12, 1'b1, 2'd0, 32'hC, 32'h0, 3'b000, 32'hC, acc);
    check_eq("bp_reject_c", {63'h0, acc}, 64'd0);
    check_eq("bp_hold_a", {32'h0, out_result}, 64'hA);
    check_eq("bp_hold_rd", {59'h0, out_rd}, 64'd10);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++)
      drive_rec(5'd12, 1'b1, 2'd0, 32'hC, 32'h0, 3'b000, 32'hC, acc);
    check_eq("bp_accept_c", {63'h0, acc}, 64'd1);
    in_valid = 1'b0;
    drain();
    check_eq("bp_in_ready_back", {63'h0, in_ready}, 64'd1);

    // Flush with both entries full and a live input
    out_ready = 1'b0;
    drive_rec(5'd4, 1'b1, 2'd0, 32'h44, 32'h0, 3'b000, 32'h44, acc);
    drive_rec(5'd5, 1'b1, 2'd0, 32'h45, 32'h0, 3'b000, 32'h45, acc);
    flush = 1'b1;
    in_valid = 1'b1; in_rd = 5'd6; in_alu_result = 32'h46;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check_eq("flush_out_valid", {63'h0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'h0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("flush_input_dropped", {63'h0, out_valid}, 64'd0);

    // Async reset mid-stall
    out_ready = 1'b0;
    drive_rec(5'd8, 1'b1, 2'd0, 32'h88, 32'h0, 3'b000, 32'h88, acc);
    drive_rec(5'd9, 1'b1, 2'd0, 32'h99, 32'h0, 3'b000, 32'h99, acc);
    in_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check_eq("arst_out_valid", {63'h0, out_valid}, 64'd0);
    check_eq("arst_out_regwrite", {63'h0, out_regwrite}, 64'd0);
    check_eq("arst_out_rd", {59'h0, out_rd}, 64'd0);
    check_eq("arst_out_result", {32'h0, out_result}, 64'd0);
    check_eq("arst_in_ready", {63'h0, in_ready}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;

    // 64-bit loads from the upper word
    d_valid = 1'b1; d_mem = 64'h80FF7F01_00000000; d_alu = 64'h2004; d_f3 = 3'b110;
    @(posedge clk); #1;
    check_eq("x64_lwu", d_out_result, 64'h0000000080FF7F01);
    d_f3 = 3'b010;
    @(posedge clk); #1;
    check_eq("x64_lw", d_out_result, 64'hFFFFFFFF80FF7F01);
    d_f3 = 3'b011;
    @(posedge clk); #1;
    check_eq("x64_ld", d_out_result, 64'h80FF7F01_00000000);
    d_valid = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
